// File: rtl/uart_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
package uart_pkg;

  // Transmit FSM states; StParity is only reachable when parity is compiled in.
  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } uart_state_e;

  // Register offsets, decoded from addr[3:2].
  localparam logic [1:0] UART_REG_TXDATA = 2'd0;
  localparam logic [1:0] UART_REG_STATUS = 2'd1;
  localparam logic [1:0] UART_REG_BAUD   = 2'd2;

  // STATUS register bit positions.
  localparam int unsigned STATUS_BUSY    = 0;
  localparam int unsigned STATUS_FULL    = 1;
  localparam int unsigned STATUS_EMPTY   = 2;
  localparam int unsigned STATUS_OVF     = 3;
  localparam int unsigned STATUS_CNT_LSB = 4;

  // Smallest usable bit period in clocks.
  localparam logic [15:0] MIN_PERIOD = 16'd2;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO with wrap-bit pointers. The head entry is visible on
// popData without a pop (first-word fall-through).
module uart_tx_fifo #(
  parameter int unsigned Depth = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [7:0]               pushData,
  input  logic                     pop,
  output logic [7:0]               popData,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(Depth):0]   count
);
  localparam int unsigned AW = $clog2(Depth);

  logic [7:0]  mem [Depth];
  logic [AW:0] wrPtrQ, rdPtrQ;
  logic        doPush, doPop;

  assign empty   = (wrPtrQ == rdPtrQ);
  assign full    = (wrPtrQ[AW] != rdPtrQ[AW]) && (wrPtrQ[AW-1:0] == rdPtrQ[AW-1:0]);
  assign count   = wrPtrQ - rdPtrQ;
  assign popData = mem[rdPtrQ[AW-1:0]];

  // A push into a full FIFO is still accepted if a pop frees a slot this cycle.
  assign doPop  = pop && !empty;
  assign doPush = push && (!full || doPop);

  // Pointer update.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtrQ <= '0;
      rdPtrQ <= '0;
    end else begin
      if (doPush) wrPtrQ <= wrPtrQ + 1'b1;
      if (doPop)  rdPtrQ <= rdPtrQ + 1'b1;
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtrQ[AW-1:0]] <= pushData;
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: register decode, TX FIFO, framing FSM and
// baud counter. Define UART_TX_PARITY_EN to add a parity bit (even by
// default, odd when BAUDDIV bit 16 is set).
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned DEFAULT_DIV = 868
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic        wr_en,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tx
);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]      regSel;
  logic            wrTx, wrStatus, wrBaud;
  logic            fifoPop, fifoFull, fifoEmpty;
  logic [7:0]      fifoData;
  logic [CntW-1:0] fifoCount;
  logic [4:0]      cntExt;

  uart_state_e     stateQ, stateD;
  logic [15:0]     divQ, periodQ, baudCntQ;
  logic [2:0]      bitIdxQ;
  logic [7:0]      shiftQ;
  logic            overflowQ;
  logic            bitDone, txD, busy;
  logic [31:0]     statusWord, baudWord;
  logic            unusedBits;
`ifdef UART_TX_PARITY_EN
  logic            parOddQ, parBitQ;
`endif

  assign regSel   = addr[3:2];
  assign wrTx     = sel && wr_en && (regSel == UART_REG_TXDATA);
  assign wrStatus = sel && wr_en && (regSel == UART_REG_STATUS);
  assign wrBaud   = sel && wr_en && (regSel == UART_REG_BAUD);

  uart_tx_fifo #(
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (wrTx),
    .pushData(wdata[7:0]),
    .pop     (fifoPop),
    .popData (fifoData),
    .full    (fifoFull),
    .empty   (fifoEmpty),
    .count   (fifoCount)
  );

  assign fifoPop = (stateQ == StIdle) && !fifoEmpty;
  assign bitDone = (baudCntQ == periodQ - 16'd1);
  assign cntExt  = 5'(fifoCount);

  // Baud divisor register (and parity sense when compiled in).
  always_ff @(posedge clk) begin
    if (reset) begin
      divQ <= 16'(DEFAULT_DIV);
    end else if (wrBaud) begin
      divQ <= wdata[15:0];
    end
  end

`ifdef UART_TX_PARITY_EN
  // Parity sense select, BAUDDIV bit 16.
  always_ff @(posedge clk) begin
    if (reset) begin
      parOddQ <= 1'b0;
    end else if (wrBaud) begin
      parOddQ <= wdata[16];
    end
  end
`endif

  // Sticky overflow: set on a dropped push, cleared by any STATUS write.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflowQ <= 1'b0;
    end else if (wrStatus) begin
      overflowQ <= 1'b0;
    end else if (wrTx && fifoFull && !fifoPop) begin
      overflowQ <= 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ <= StIdle;
    end else begin
      stateQ <= stateD;
    end
  end

  // FSM next-state logic.
  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      StIdle:  if (!fifoEmpty) stateD = StStart;
      StStart: if (bitDone) stateD = StData;
      StData: begin
        if (bitDone && (bitIdxQ == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
          stateD = StParity;
`else
          stateD = StStop;
`endif
        end
      end
      StParity: if (bitDone) stateD = StStop;
      StStop:   if (bitDone) stateD = StIdle;
      default:  stateD = StIdle;
    endcase
  end

  // FSM outputs: line level for the current state and busy flag.
  always_comb begin
    txD  = 1'b1;
    busy = (stateQ != StIdle);
    unique case (stateQ)
      StIdle:  txD = 1'b1;
      StStart: txD = 1'b0;
      StData:  txD = shiftQ[0];
`ifdef UART_TX_PARITY_EN
      StParity: txD = parBitQ;
`else
      StParity: txD = 1'b1;
`endif
      StStop:  txD = 1'b1;
      default: txD = 1'b1;
    endcase
  end

  // Registered line driver so tx is glitch-free.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx <= 1'b1;
    end else begin
      tx <= txD;
    end
  end

  // Frame datapath: load on pop, then count bit periods and shift data bits.
  // The divisor is latched at the pop so mid-frame writes affect the next frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      shiftQ   <= '0;
      periodQ  <= MIN_PERIOD;
      baudCntQ <= '0;
      bitIdxQ  <= '0;
    end else if (fifoPop) begin
      shiftQ   <= fifoData;
      periodQ  <= (divQ < MIN_PERIOD) ? MIN_PERIOD : divQ;
      baudCntQ <= '0;
      bitIdxQ  <= '0;
    end else if (stateQ != StIdle) begin
      if (bitDone) begin
        baudCntQ <= '0;
        if (stateQ == StData) begin
          shiftQ  <= {1'b0, shiftQ[7:1]};
          bitIdxQ <= bitIdxQ + 3'd1;
        end
      end else begin
        baudCntQ <= baudCntQ + 16'd1;
      end
    end
  end

`ifdef UART_TX_PARITY_EN
  // Parity bit computed once from the popped byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      parBitQ <= 1'b0;
    end else if (fifoPop) begin
      parBitQ <= (^fifoData) ^ parOddQ;
    end
  end
`endif

  // Read-back words.
  always_comb begin
    statusWord                               = '0;
    statusWord[STATUS_BUSY]                  = busy;
    statusWord[STATUS_FULL]                  = fifoFull;
    statusWord[STATUS_EMPTY]                 = fifoEmpty;
    statusWord[STATUS_OVF]                   = overflowQ;
    statusWord[STATUS_CNT_LSB+3:STATUS_CNT_LSB] = cntExt[3:0];
    baudWord                                 = {16'd0, divQ};
`ifdef UART_TX_PARITY_EN
    baudWord[16]                             = parOddQ;
`endif
  end

  // Zero-wait-state read mux; quiet when not selected.
  always_comb begin
    rdata = '0;
    if (sel) begin
      unique case (regSel)
        UART_REG_STATUS: rdata = statusWord;
        UART_REG_BAUD:   rdata = baudWord;
        default:         rdata = '0;
      endcase
    end
  end

`ifdef UART_TX_PARITY_EN
  assign unusedBits = ^{addr[31:4], addr[1:0], wdata[31:17], cntExt[4]};
`else
  assign unusedBits = ^{addr[31:4], addr[1:0], wdata[31:16], cntExt[4]};
`endif

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Scoreboard bench for uart_tx_mmio: stimulus queues expected register reads
// and expected serial frames; two monitors pop and compare.
module tb_uart_tx_mmio;

  logic        clk, reset, sel, wr_en, rdStrobe;
  logic [31:0] addr, wdata, rdata;
  logic        tx;

  typedef struct {
    logic [7:0] data;
    int         period;
    logic       par;
  } frame_t;

  frame_t      frameQ[$];
  string       rdNameQ[$];
  logic [31:0] rdExpQ[$];
  int          nChecks = 0;
  int          nFail = 0;
  int          framesPushed = 0;
  int          framesStarted = 0;

  uart_tx_mmio #(
    .FIFO_DEPTH (8),
    .DEFAULT_DIV(868)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .sel  (sel),
    .wr_en(wr_en),
    .addr (addr),
    .wdata(wdata),
    .rdata(rdata),
    .tx   (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  task automatic busWrite(input logic [3:0] a, input logic [31:0] d);
    sel = 1'b1; wr_en = 1'b1; addr = 32'h4000_1000 | {28'h0, a}; wdata = d;
    @(posedge clk); #1;
    sel = 1'b0; wr_en = 1'b0; addr = '0; wdata = '0;
  endtask

  task automatic busRead(input string name, input logic [3:0] a, input logic s,
                         input logic [31:0] exp);
    sel = s; wr_en = 1'b0; addr = 32'h4000_1000 | {28'h0, a}; rdStrobe = 1'b1;
    rdNameQ.push_back(name);
    rdExpQ.push_back(exp);
    @(posedge clk); #1;
    sel = 1'b0; rdStrobe = 1'b0; addr = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sendByte(input logic [7:0] d, input int period, input logic par);
    frame_t f;
    f.data = d; f.period = period; f.par = par;
    frameQ.push_back(f);
    framesPushed++;
    busWrite(4'h0, {24'h0, d});
  endtask

  // Read monitor: compares rdata against the queued expectation.
  initial begin : readMon
    string       n;
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (rdStrobe) begin
        if (rdExpQ.size() == 0) begin
          nChecks++; nFail++;
          $display("FAIL read_queue: read with no expectation, got 0x%0h", rdata);
        end else begin
          n = rdNameQ.pop_front();
          e = rdExpQ.pop_front();
          check(n, rdata, e);
        end
      end
    end
  end

  // Frame monitor: on a start edge, checks every clock of every bit.
  initial begin : frameMon
    logic        txPrev, got, aborted;
    frame_t      f;
    logic [10:0] bits;
    int          nb;
    txPrev = 1'b1;
    forever begin
      @(negedge clk);
      if (!reset && txPrev === 1'b1 && tx === 1'b0) begin
        framesStarted++;
        if (frameQ.size() == 0) begin
          nChecks++; nFail++;
          $display("FAIL unexpected_frame: start bit seen, got tx=0, expected idle 1");
        end else begin
          f = frameQ.pop_front();
`ifdef UART_TX_PARITY_EN
          bits = {1'b1, f.par, f.data, 1'b0};
          nb = 11;
`else
          bits = {2'b11, f.data, 1'b0};
          nb = 10;
`endif
          aborted = 1'b0;
          for (int b = 0; b < nb && !aborted; b++) begin
            got = bits[b];
            for (int c = 0; c < f.period && !aborted; c++) begin
              if (b != 0 || c != 0) @(negedge clk);
              if (reset) aborted = 1'b1;
              else if (tx !== bits[b]) got = tx;
            end
            if (!aborted)
              check($sformatf("frame_%02h_bit%0d", f.data, b), {31'h0, got}, {31'h0, bits[b]});
          end
        end
      end
      txPrev = tx;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    sel = 1'b0; wr_en = 1'b0; addr = '0; wdata = '0; rdStrobe = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state and register map.
    check("reset_tx", {31'h0, tx}, 32'h1);
    busRead("reset_status", 4'h4, 1'b1, 32'h0000_0004);
    busRead("reset_baud", 4'h8, 1'b1, 32'd868);
    busRead("sel_low_zero", 4'h4, 1'b0, 32'h0);
`ifdef UART_TX_PARITY_EN
    busWrite(4'h8, 32'hFFFF_FFFF);
    busRead("baud_upper_bits", 4'h8, 1'b1, 32'h0001_FFFF);
`else
    busWrite(4'h8, 32'hFFFF_FFFF);
    busRead("baud_upper_bits", 4'h8, 1'b1, 32'h0000_FFFF);
`endif
    busWrite(4'hC, 32'hDEAD_BEEF);
    busRead("reserved_zero", 4'hC, 1'b1, 32'h0);
    busRead("txdata_reads_zero", 4'h0, 1'b1, 32'h0);
    busWrite(4'h8, 32'd4);
    busRead("baud4", 4'h8, 1'b1, 32'd4);

    // 0xA5 at divisor 4: start edge timing and busy throughout.
    sendByte(8'hA5, 4, 1'b0);
    check("tx_high_after_write", {31'h0, tx}, 32'h1);
    busRead("status_queued", 4'h4, 1'b1, 32'h0000_0010);
    check("tx_high_at_pop", {31'h0, tx}, 32'h1);
    busRead("status_busy_first", 4'h4, 1'b1, 32'h0000_0005);
    check("tx_start_edge", {31'h0, tx}, 32'h0);
    for (int i = 0; i < 36; i++) busRead("status_busy", 4'h4, 1'b1, 32'h0000_0005);
    idle(10);
    busRead("status_idle_after_a5", 4'h4, 1'b1, 32'h0000_0004);

    // Divisor clamp: 0 behaves as 2.
    busWrite(4'h8, 32'd0);
    busRead("baud0", 4'h8, 1'b1, 32'd0);
    sendByte(8'h00, 2, 1'b0);
    idle(40);

`ifdef UART_TX_PARITY_EN
    busWrite(4'h8, 32'd4);
    sendByte(8'h07, 4, 1'b1);
    idle(60);
    busWrite(4'h8, 32'h0001_0004);
    busRead("baud_odd", 4'h8, 1'b1, 32'h0001_0004);
    sendByte(8'h07, 4, 1'b0);
    idle(60);
`endif

    // Overflow: ten back-to-back pushes at a slow divisor.
    busWrite(4'h8, 32'd100);
    frameQ.push_back('{data: 8'h30, period: 100, par: 1'b0});
    frameQ.push_back('{data: 8'h31, period: 100, par: 1'b1});
    frameQ.push_back('{data: 8'h32, period: 100, par: 1'b1});
    frameQ.push_back('{data: 8'h33, period: 100, par: 1'b0});
    frameQ.push_back('{data: 8'h34, period: 100, par: 1'b1});
    frameQ.push_back('{data: 8'h35, period: 100, par: 1'b0});
    frameQ.push_back('{data: 8'h36, period: 100, par: 1'b0});
    frameQ.push_back('{data: 8'h37, period: 100, par: 1'b1});
    frameQ.push_back('{data: 8'h38, period: 100, par: 1'b1});
    framesPushed += 9;
    for (int i = 0; i < 10; i++) busWrite(4'h0, 32'h30 + i);
    busRead("status_overflow", 4'h4, 1'b1, 32'h0000_008B);
    busWrite(4'h4, 32'h0);
    busRead("status_ovf_cleared", 4'h4, 1'b1, 32'h0000_0083);
    for (int i = 0; i < 12000 && frameQ.size() != 0; i++) @(posedge clk);
    #1;
    check("drain_frames_left", frameQ.size(), 0);
    idle(1200);
    busRead("status_drained", 4'h4, 1'b1, 32'h0000_0004);

    // Reset during data bit 3.
    busWrite(4'h8, 32'd4);
    sendByte(8'h5A, 4, 1'b0);
    idle(18);
    reset = 1'b1;
    @(posedge clk); #1;
    check("tx_high_after_reset", {31'h0, tx}, 32'h1);
    reset = 1'b0;
    busRead("status_after_reset", 4'h4, 1'b1, 32'h0000_0004);
    busRead("baud_after_reset", 4'h8, 1'b1, 32'd868);
    idle(300);

    check("frames_started", framesStarted, framesPushed);
    check("reads_pending", rdExpQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
